// File: rtl/clk_pkg.sv
// Shared clock-generation definitions: ratio width default, minimum legal
// ratio, and the high-phase length helper used by the integer and fractional dividers.
package clk_pkg;

  localparam int unsigned RATIO_WD_DEF = 8;
  localparam int unsigned RATIO_WD_MAX = 32;
  localparam int unsigned MIN_RATIO    = 2;

  // High-phase length: floor(N/2), plus one for odd N when the high phase is biased long.
  function automatic logic [RATIO_WD_MAX-1:0] half_high(
    input logic [RATIO_WD_MAX-1:0] ratio,
    input logic                    odd_hi
  );
    return (ratio >> 1) + {{(RATIO_WD_MAX-1){1'b0}}, ratio[0] & odd_hi};
  endfunction

endpackage

// File: rtl/clk_div_mux.sv
// Registered-select 2:1 clock mux; kept as its own cell so it can be
// mapped to a dedicated clock mux and protected from restructuring.
module clk_div_mux (
  input  logic ref_clk,
  input  logic div_clk,
  input  logic sel,
  output logic clk_out
);

  assign clk_out = sel ? div_clk : ref_clk;

endmodule

// File: rtl/clk_div_gf.sv
// Glitch-free integer clock divider with bypass, shadowed ratio/enable
// applied only at period boundaries, and reference-domain edge strobes.
module clk_div_gf
  import clk_pkg::*;
#(
  parameter int unsigned RATIO_WD = RATIO_WD_DEF,
  parameter bit          ODD_HI   = 1'b1
) (
  input  logic                i_ref_clk,
  input  logic                i_rst,
  input  logic                i_clk_en,
  input  logic [RATIO_WD-1:0] i_div_ratio,
  output logic                o_div_clk,
  output logic                o_rise_stb,
  output logic                o_fall_stb,
  output logic                o_upd_stb,
  output logic                o_active
);

  logic [RATIO_WD-1:0] act_ratio_q, act_ratio_d;
  logic                act_en_q, act_en_d;
  logic [RATIO_WD-1:0] cnt_q, cnt_d;
  logic                div_clk_q, div_clk_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                upd_q, upd_d;
  logic                active_q, active_d;

  logic [RATIO_WD-1:0] high_len;
  logic [RATIO_WD-1:0] cnt_inc;
  logic                div_ok;
  logic                new_ok;
  logic                bnd;

  // Next-state: reload shadows at a boundary, otherwise advance within the period.
  always_comb begin
    act_ratio_d = act_ratio_q;
    act_en_d    = act_en_q;
    cnt_d       = cnt_q;
    div_clk_d   = div_clk_q;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    upd_d       = 1'b0;
    active_d    = active_q;

    high_len = RATIO_WD'(half_high(RATIO_WD_MAX'(act_ratio_q), ODD_HI));
    cnt_inc  = cnt_q + RATIO_WD'(1);
    div_ok   = act_en_q && (act_ratio_q >= RATIO_WD'(MIN_RATIO));
    new_ok   = i_clk_en && (i_div_ratio >= RATIO_WD'(MIN_RATIO));
    bnd      = !div_ok || (cnt_q == act_ratio_q - RATIO_WD'(1));

    if (bnd) begin
      act_ratio_d = i_div_ratio;
      act_en_d    = i_clk_en;
      cnt_d       = '0;
      div_clk_d   = new_ok;
      active_d    = new_ok;
      rise_d      = new_ok;
      upd_d       = {i_clk_en, i_div_ratio} != {act_en_q, act_ratio_q};
    end else begin
      cnt_d     = cnt_inc;
      div_clk_d = cnt_inc < high_len;
      fall_d    = active_q && (cnt_inc == high_len);
    end
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      act_ratio_q <= '0;
      act_en_q    <= 1'b0;
      cnt_q       <= '0;
      div_clk_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      upd_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      act_ratio_q <= act_ratio_d;
      act_en_q    <= act_en_d;
      cnt_q       <= cnt_d;
      div_clk_q   <= div_clk_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      upd_q       <= upd_d;
      active_q    <= active_d;
    end
  end

  assign o_rise_stb = rise_q;
  assign o_fall_stb = fall_q;
  assign o_upd_stb  = upd_q;
  assign o_active   = active_q;

  clk_div_mux u_mux (
    .ref_clk (i_ref_clk),
    .div_clk (div_clk_q),
    .sel     (active_q),
    .clk_out (o_div_clk)
  );

endmodule

// File: tb/tb_clk_div_gf.sv
// Scoreboard bench for clk_div_gf: a period-level reference model pushes the
// expected per-cycle waveform; a monitor pops and compares every cycle.
module tb_clk_div_gf;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [7:0] div_ratio;

  logic div_clk1, rise1, fall1, upd1, act1;
  logic div_clk0, rise0, fall0, upd0, act0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit act;
    bit rise;
    bit upd;
    bit div1;
    bit fall1;
    bit div0;
    bit fall0;
  } exp_t;

  exp_t exp_q[$];
  bit       prev_en    = 1'b0;
  int       prev_ratio = 0;

  always #5 clk = ~clk;

  clk_div_gf #(.RATIO_WD(8), .ODD_HI(1'b1)) dut_hi (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk1),
    .o_rise_stb  (rise1),
    .o_fall_stb  (fall1),
    .o_upd_stb   (upd1),
    .o_active    (act1)
  );

  clk_div_gf #(.RATIO_WD(8), .ODD_HI(1'b0)) dut_lo (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_clk_en    (clk_en),
    .i_div_ratio (div_ratio),
    .o_div_clk   (div_clk0),
    .o_rise_stb  (rise0),
    .o_fall_stb  (fall0),
    .o_upd_stb   (upd0),
    .o_active    (act0)
  );

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Expand one whole period (or one bypass cycle) from the sampled request.
  task automatic push_period(input bit en, input int n);
    exp_t e;
    bit   changed;
    int   high_hi, high_lo;
    changed = (en != prev_en) || (n != prev_ratio);
    prev_en    = en;
    prev_ratio = n;
    if (en && n >= 2) begin
      high_hi = (n + 1) / 2;
      high_lo = n / 2;
      for (int k = 0; k < n; k++) begin
        e.act   = 1'b1;
        e.rise  = (k == 0);
        e.upd   = (k == 0) && changed;
        e.div1  = (k < high_hi);
        e.fall1 = (k == high_hi);
        e.div0  = (k < high_lo);
        e.fall0 = (k == high_lo);
        exp_q.push_back(e);
      end
    end else begin
      e = '{act: 1'b0, rise: 1'b0, upd: changed, div1: 1'b0, fall1: 1'b0,
            div0: 1'b0, fall0: 1'b0};
      exp_q.push_back(e);
    end
  endtask

  // Reference model: a new period begins when the previous one is fully consumed.
  always @(posedge clk) begin
    if (!rst && exp_q.size() == 0)
      push_period(clk_en, int'(div_ratio));
  end

  // Monitor: output level just after posedge (ref high), then full compare after negedge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("div_clk_hi_phase", int'(div_clk1), e.act ? int'(e.div1) : 1);
      chk("div_clk_lo_phase", int'(div_clk0), e.act ? int'(e.div0) : 1);
    end
    @(negedge clk);
    #1;
    if (rst) begin
      chk("rst_div_clk", int'(div_clk1 | div_clk0), 0);
      chk("rst_active", int'(act1 | act0), 0);
      chk("rst_strobes", int'({rise1, fall1, upd1, rise0, fall0, upd0}), 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("active", int'(act1), int'(e.act));
      chk("active_lo", int'(act0), int'(e.act));
      chk("rise_stb", int'(rise1), int'(e.rise));
      chk("rise_stb_lo", int'(rise0), int'(e.rise));
      chk("upd_stb", int'(upd1), int'(e.upd));
      chk("upd_stb_lo", int'(upd0), int'(e.upd));
      chk("fall_stb_hi", int'(fall1), int'(e.fall1));
      chk("fall_stb_lo", int'(fall0), int'(e.fall0));
      chk("div_clk_hi_low_ref", int'(div_clk1), e.act ? int'(e.div1) : 0);
      chk("div_clk_lo_low_ref", int'(div_clk0), e.act ? int'(e.div0) : 0);
    end
  end

  task automatic wait_rise();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (rise1) return;
    end
    chk("rise_timeout", 0, 1);
  endtask

  task automatic set_req(input bit en, input int n, input int cycles);
    @(negedge clk);
    clk_en    = en;
    div_ratio = 8'(n);
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    clk_en    = 1'b0;
    div_ratio = 8'd0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    set_req(1'b1, 4, 40);
    set_req(1'b1, 5, 100);

    // Ratio change one cycle into a period.
    set_req(1'b1, 4, 12);
    wait_rise();
    @(negedge clk);
    div_ratio = 8'd6;
    repeat (30) @(negedge clk);

    set_req(1'b1, 1, 10);
    set_req(1'b1, 0, 10);
    set_req(1'b0, 9, 10);
    set_req(1'b1, 3, 30);

    set_req(1'b1, 255, 600);

    // Reset in the middle of a high phase.
    set_req(1'b1, 8, 4);
    wait_rise();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    prev_en    = 1'b0;
    prev_ratio = 0;
    #1;
    chk("midrst_div_clk_follows_ref", int'(div_clk1 & div_clk0), 1);
    chk("midrst_active", int'(act1 | act0), 0);
    chk("midrst_strobes", int'({rise1, fall1, upd1, rise0, fall0, upd0}), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized on-the-fly ratio/enable changes.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) begin
        clk_en = ($urandom_range(0, 7) != 0);
        case ($urandom_range(0, 3))
          0:       div_ratio = 8'($urandom_range(0, 3));
          1:       div_ratio = 8'($urandom_range(4, 20));
          2:       div_ratio = 8'($urandom_range(240, 255));
          default: div_ratio = 8'($urandom_range(0, 255));
        endcase
      end
    end
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
